// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register between two adjacent stages, steered by the central
// stall vector and exception flush, with FULL/HELD tracking and saturating counters.
module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CARRY_W   = 66,
    parameter int                STALL_W   = 6,
    parameter int                STAGE_IDX = 3,
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_payload,
    input  logic [CARRY_W-1:0] in_carry,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_payload,
    output logic [CARRY_W-1:0] out_carry,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    generate
        if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX must lie in 0..STALL_W-2");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        HELD  = 2'b10
    } state_t;

    state_t state_q;

    logic up_stall;
    logic dn_stall;
    logic do_bubble;
    logic do_advance;
    logic do_hold;

    assign up_stall   = stall[STAGE_IDX];
    assign dn_stall   = stall[STAGE_IDX+1];
    // Upstream stopped while downstream keeps going: a NOP has to be injected.
    assign do_bubble  = !flush && up_stall && !dn_stall;
    assign do_advance = !flush && !up_stall;
    assign do_hold    = !flush && up_stall && dn_stall;

    assign state = state_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_payload <= NOP_VALUE;
            out_carry   <= '0;
            state_q     <= EMPTY;
            bubble_cnt  <= '0;
            hold_cnt    <= '0;
            flush_cnt   <= '0;
        end else begin
            if (flush) begin
                out_valid   <= 1'b0;
                out_payload <= NOP_VALUE;
                out_carry   <= '0;
                state_q     <= EMPTY;
            end else if (do_bubble) begin
                // The multi-cycle op keeps accumulating even though no instruction moves.
                out_valid   <= 1'b0;
                out_payload <= NOP_VALUE;
                out_carry   <= in_carry;
                state_q     <= EMPTY;
            end else if (do_advance) begin
                out_valid   <= in_valid;
                out_payload <= in_valid ? in_payload : NOP_VALUE;
                out_carry   <= '0;
                state_q     <= in_valid ? FULL : EMPTY;
            end else begin
                out_carry   <= in_carry;
                state_q     <= out_valid ? HELD : EMPTY;
            end

            if (cnt_clr) begin
                bubble_cnt <= '0;
                hold_cnt   <= '0;
                flush_cnt  <= '0;
            end else begin
                if (do_bubble)             bubble_cnt <= sat_inc(bubble_cnt);
                if (do_hold && out_valid)  hold_cnt   <= sat_inc(hold_cnt);
                if (flush && out_valid)    flush_cnt  <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; a second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_payload;
    logic [3:0] in_carry;
    logic       cnt_clr;

    logic        a_valid;
    logic [7:0]  a_payload;
    logic [3:0]  a_carry;
    logic [1:0]  a_state;
    logic [15:0] a_bubble, a_hold, a_flush;

    logic       b_valid;
    logic [7:0] b_payload;
    logic [3:0] b_carry;
    logic [1:0] b_state;
    logic [1:0] b_bubble, b_hold, b_flush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(8), .CARRY_W(4), .STALL_W(6), .STAGE_IDX(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_payload(in_payload), .in_carry(in_carry), .cnt_clr(cnt_clr),
        .out_valid(a_valid), .out_payload(a_payload), .out_carry(a_carry), .state(a_state),
        .bubble_cnt(a_bubble), .hold_cnt(a_hold), .flush_cnt(a_flush)
    );

    pipe_stage_reg #(.DATA_W(8), .CARRY_W(4), .STALL_W(6), .STAGE_IDX(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_payload(in_payload), .in_carry(in_carry), .cnt_clr(cnt_clr),
        .out_valid(b_valid), .out_payload(b_payload), .out_carry(b_carry), .state(b_state),
        .bubble_cnt(b_bubble), .hold_cnt(b_hold), .flush_cnt(b_flush)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h want=0", a_valid); end
        total++; if (a_payload !== 8'h00) begin bad++; $display("FAIL reset_payload got=%h want=00", a_payload); end
        total++; if (a_carry !== 4'h0) begin bad++; $display("FAIL reset_carry got=%h want=0", a_carry); end
        total++; if (a_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", a_state); end
        total++; if ({a_bubble, a_hold, a_flush} !== 48'h0) begin bad++; $display("FAIL reset_counters got=%h/%h/%h want=0", a_bubble, a_hold, a_flush); end
    endtask

    task automatic test_advance();
        stall = 6'b000000; in_valid = 1'b1; in_payload = 8'hA5; in_carry = 4'h7;
        step();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL adv_valid got=%h want=1", a_valid); end
        total++; if (a_payload !== 8'hA5) begin bad++; $display("FAIL adv_payload got=%h want=a5", a_payload); end
        total++; if (a_carry !== 4'h0) begin bad++; $display("FAIL adv_carry got=%h want=0", a_carry); end
        total++; if (a_state !== 2'b01) begin bad++; $display("FAIL adv_state got=%b want=01", a_state); end
    endtask

    task automatic test_bubble();
        stall = 6'b001000; in_carry = 4'h9; in_payload = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL bub_valid[%0d] got=%h want=0", i, a_valid); end
            total++; if (a_payload !== 8'h00) begin bad++; $display("FAIL bub_payload[%0d] got=%h want=00", i, a_payload); end
            total++; if (a_carry !== 4'h9) begin bad++; $display("FAIL bub_carry[%0d] got=%h want=9", i, a_carry); end
            total++; if (a_state !== 2'b00) begin bad++; $display("FAIL bub_state[%0d] got=%b want=00", i, a_state); end
        end
        total++; if (a_bubble !== 16'd3) begin bad++; $display("FAIL bub_cnt got=%0d want=3", a_bubble); end
    endtask

    task automatic test_hold();
        stall = 6'b000000; in_valid = 1'b1; in_payload = 8'h3C;
        step();
        total++; if (a_payload !== 8'h3C) begin bad++; $display("FAIL hold_load got=%h want=3c", a_payload); end
        stall = 6'b011000; in_carry = 4'h5;
        for (int i = 0; i < 4; i++) begin
            in_payload = 8'(8'h50 + i);
            step();
            total++; if (a_payload !== 8'h3C) begin bad++; $display("FAIL hold_payload[%0d] got=%h want=3c", i, a_payload); end
            total++; if (a_state !== 2'b10) begin bad++; $display("FAIL hold_state[%0d] got=%b want=10", i, a_state); end
            total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%h want=1", i, a_valid); end
        end
        total++; if (a_carry !== 4'h5) begin bad++; $display("FAIL hold_carry got=%h want=5", a_carry); end
        total++; if (a_hold !== 16'd4) begin bad++; $display("FAIL hold_cnt got=%0d want=4", a_hold); end
        stall = 6'b000000; in_payload = 8'h11;
        step();
        total++; if (a_payload !== 8'h11) begin bad++; $display("FAIL release_payload got=%h want=11", a_payload); end
        total++; if (a_state !== 2'b01) begin bad++; $display("FAIL release_state got=%b want=01", a_state); end
    endtask

    task automatic test_flush();
        stall = 6'b011000; in_carry = 4'hC;
        step();
        total++; if (a_state !== 2'b10) begin bad++; $display("FAIL flush_pre_state got=%b want=10", a_state); end
        flush = 1'b1;
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%h want=0", a_valid); end
        total++; if (a_carry !== 4'h0) begin bad++; $display("FAIL flush_carry got=%h want=0", a_carry); end
        total++; if (a_state !== 2'b00) begin bad++; $display("FAIL flush_state got=%b want=00", a_state); end
        total++; if (a_flush !== 16'd1) begin bad++; $display("FAIL flush_cnt got=%0d want=1", a_flush); end
        total++; if (a_hold !== 16'd5) begin bad++; $display("FAIL flush_hold_cnt got=%0d want=5", a_hold); end
        // Flushing an already-empty register must not count.
        step();
        total++; if (a_flush !== 16'd1) begin bad++; $display("FAIL flush_empty_cnt got=%0d want=1", a_flush); end
        flush = 1'b0;
    endtask

    task automatic test_empty_paths();
        stall = 6'b000000; in_valid = 1'b0; in_payload = 8'hFF;
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL advinv_valid got=%h want=0", a_valid); end
        total++; if (a_payload !== 8'h00) begin bad++; $display("FAIL advinv_payload got=%h want=00", a_payload); end
        stall = 6'b011000; in_carry = 4'h3;
        step();
        total++; if (a_state !== 2'b00) begin bad++; $display("FAIL holdempty_state got=%b want=00", a_state); end
        total++; if (a_hold !== 16'd5) begin bad++; $display("FAIL holdempty_cnt got=%0d want=5", a_hold); end
        total++; if (a_carry !== 4'h3) begin bad++; $display("FAIL holdempty_carry got=%h want=3", a_carry); end
    endtask

    task automatic test_saturation();
        rst = 1'b1; step(); rst = 1'b0;
        stall = 6'b001000;
        for (int i = 0; i < 5; i++) step();
        total++; if (b_bubble !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d want=3", b_bubble); end
        total++; if (a_bubble !== 16'd5) begin bad++; $display("FAIL wide_cnt got=%0d want=5", a_bubble); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        total++; if (b_bubble !== 2'd0) begin bad++; $display("FAIL clr_narrow got=%0d want=0", b_bubble); end
        total++; if (a_bubble !== 16'd0) begin bad++; $display("FAIL clr_wide got=%0d want=0", a_bubble); end
    endtask

    task automatic test_reset_mid_hold();
        stall = 6'b000000; in_valid = 1'b1; in_payload = 8'h77;
        step();
        stall = 6'b011000; in_carry = 4'hF;
        step();
        total++; if (a_state !== 2'b10 || a_carry !== 4'hF) begin bad++; $display("FAIL midhold_pre got=%b/%h want=10/f", a_state, a_carry); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({a_valid, a_payload, a_carry, a_state} !== 15'h0) begin bad++; $display("FAIL midhold_outputs got=%h/%h/%h/%b want=0", a_valid, a_payload, a_carry, a_state); end
        total++; if ({a_bubble, a_hold, a_flush} !== 48'h0) begin bad++; $display("FAIL midhold_counters got=%h/%h/%h want=0", a_bubble, a_hold, a_flush); end
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0;
        in_payload = '0; in_carry = '0; cnt_clr = 1'b0;
        #2;
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_empty_paths();
        test_saturation();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
